// File: rtl/uart_tx_arbiter.sv
// Round-robin byte scheduler sharing one UART transmitter, plus the 16x oversample tick generator.
// Define UART_TX_ARB_PKT_LOCK_EN to honour req_last and keep multi-byte packets contiguous.
`timescale 1ns/1ps
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DIV_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [DIV_WIDTH-1:0]         baud_div,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*8-1:0]         req_data,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         clk_enable,
    output logic                         tx_data_valid,
    output logic [7:0]                   tx_data,
    input  logic                         tx_data_ready,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         busy
);

    localparam int GW = $clog2(NUM_REQ);

`ifdef UART_TX_ARB_PKT_LOCK_EN
    typedef enum logic [1:0] {IDLE, SEND, LOCK} state_t;
`else
    typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif

    state_t               state_q, state_d;
    logic [DIV_WIDTH-1:0] divCnt_q, divCnt_d;
    logic                 clkEnable_q, clkEnable_d;
    logic                 txValid_q, txValid_d;
    logic [7:0]           txData_q, txData_d;
    logic [GW-1:0]        grant_q, grant_d;
    logic [GW-1:0]        rrPtr_q, rrPtr_d;
    logic                 accept;
    logic                 found;
    logic [GW-1:0]        pick;

`ifdef UART_TX_ARB_PKT_LOCK_EN
    logic                 last_q, last_d;
`else
    logic                 unusedLast;
    assign unusedLast = ^req_last;
`endif

    function automatic logic [GW-1:0] wrapAdd(input logic [GW-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return GW'(sum);
    endfunction

    // The tick is registered so it is guaranteed low while reset is held, even with baud_div = 0.
    always_comb begin
        clkEnable_d = 1'b0;
        divCnt_d    = divCnt_q + 1'b1;
        if (divCnt_q >= baud_div) begin
            clkEnable_d = 1'b1;
            divCnt_d    = '0;
        end
    end

    always_comb begin
        found = 1'b0;
        pick  = rrPtr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[wrapAdd(rrPtr_q, i)]) begin
                found = 1'b1;
                pick  = wrapAdd(rrPtr_q, i);
            end
        end
    end

    assign accept = txValid_q && tx_data_ready && clkEnable_q;

    always_comb begin
        state_d   = state_q;
        txValid_d = txValid_q;
        txData_d  = txData_q;
        grant_d   = grant_q;
        rrPtr_d   = rrPtr_q;
        req_ready = '0;
`ifdef UART_TX_ARB_PKT_LOCK_EN
        last_d    = last_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    req_ready[pick] = 1'b1;
                    txData_d        = req_data[{pick, 3'b000} +: 8];
                    txValid_d       = 1'b1;
                    grant_d         = pick;
`ifdef UART_TX_ARB_PKT_LOCK_EN
                    last_d          = req_last[pick];
`endif
                    state_d         = SEND;
                end
            end
            SEND: begin
                if (accept) begin
                    txValid_d = 1'b0;
`ifdef UART_TX_ARB_PKT_LOCK_EN
                    if (last_q) begin
                        rrPtr_d = wrapAdd(grant_q, 1);
                        state_d = IDLE;
                    end else begin
                        state_d = LOCK;
                    end
`else
                    rrPtr_d = wrapAdd(grant_q, 1);
                    state_d = IDLE;
`endif
                end
            end
`ifdef UART_TX_ARB_PKT_LOCK_EN
            // Mid-packet: only the owner may continue, everyone else waits for its last byte.
            LOCK: begin
                if (req_valid[grant_q]) begin
                    req_ready[grant_q] = 1'b1;
                    txData_d           = req_data[{grant_q, 3'b000} +: 8];
                    txValid_d          = 1'b1;
                    last_d             = req_last[grant_q];
                    state_d            = SEND;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            divCnt_q    <= '0;
            clkEnable_q <= 1'b0;
            txValid_q   <= 1'b0;
            txData_q    <= '0;
            grant_q     <= '0;
            rrPtr_q     <= '0;
`ifdef UART_TX_ARB_PKT_LOCK_EN
            last_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            divCnt_q    <= divCnt_d;
            clkEnable_q <= clkEnable_d;
            txValid_q   <= txValid_d;
            txData_q    <= txData_d;
            grant_q     <= grant_d;
            rrPtr_q     <= rrPtr_d;
`ifdef UART_TX_ARB_PKT_LOCK_EN
            last_q      <= last_d;
`endif
        end
    end

    assign clk_enable    = clkEnable_q;
    assign tx_data_valid = txValid_q;
    assign tx_data       = txData_q;
    assign grant_id      = grant_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (4 requesters); packet-lock scenario
// is exercised when UART_TX_ARB_PKT_LOCK_EN is defined.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] baud_div;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        clk_enable;
    logic        tx_data_valid;
    logic [7:0]  tx_data;
    logic        tx_data_ready;
    logic [1:0]  grant_id;
    logic        busy;

    int checks = 0;
    int fails  = 0;

    uart_tx_arbiter #(.NUM_REQ(4), .DIV_WIDTH(16)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .baud_div      (baud_div),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .clk_enable    (clk_enable),
        .tx_data_valid (tx_data_valid),
        .tx_data       (tx_data),
        .tx_data_ready (tx_data_ready),
        .grant_id      (grant_id),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Called at a falling edge; returns once a pop strobe is visible or the budget runs out.
    task automatic waitForPop(input int limit, output bit seen);
        seen = 1'b0;
        for (int n = 0; n < limit; n++) begin
            #1;
            if (req_ready != 4'b0000) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic pulseReset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; baud_div = 16'd3; req_valid = '0; req_data = '0;
        req_last = 4'hF; tx_data_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (clk_enable !== 1'b0) begin fails++; $display("[TB] FAIL reset_clk_enable: got %b want 0", clk_enable); end
        checks++; if (tx_data_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_tx_valid: got %b want 0", tx_data_valid); end
        checks++; if (tx_data !== 8'h00) begin fails++; $display("[TB] FAIL reset_tx_data: got %h want 00", tx_data); end
        checks++; if (grant_id !== 2'd0) begin fails++; $display("[TB] FAIL reset_grant: got %0d want 0", grant_id); end
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        checks++; if (req_ready !== 4'b0000) begin fails++; $display("[TB] FAIL reset_req_ready: got %b want 0000", req_ready); end
    endtask

    task automatic test_tick();
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            checks++;
            if (clk_enable !== ((k % 4) == 0)) begin
                fails++; $display("[TB] FAIL tick_div3 cycle %0d: got %b want %b", k, clk_enable, (k % 4) == 0);
            end
        end
        baud_div = 16'd0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checks++;
            if (clk_enable !== 1'b1) begin fails++; $display("[TB] FAIL tick_div0 cycle %0d: got %b want 1", k, clk_enable); end
        end
    endtask

    task automatic test_single_byte();
        @(negedge clk);
        tx_data_ready = 1'b1; req_last = 4'hF;
        req_data = 32'h00A5_0000; req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin fails++; $display("[TB] FAIL single_pop: got %b want 0100", req_ready); end
        @(negedge clk);
        checks++; if (tx_data !== 8'hA5) begin fails++; $display("[TB] FAIL single_data: got %h want a5", tx_data); end
        checks++; if (tx_data_valid !== 1'b1) begin fails++; $display("[TB] FAIL single_valid: got %b want 1", tx_data_valid); end
        checks++; if (grant_id !== 2'd2) begin fails++; $display("[TB] FAIL single_grant: got %0d want 2", grant_id); end
        checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL single_busy: got %b want 1", busy); end
        checks++; if (req_ready !== 4'b0000) begin fails++; $display("[TB] FAIL single_no_pop_in_send: got %b want 0000", req_ready); end
        req_valid = 4'b0000;
        @(negedge clk);
        checks++; if (tx_data_valid !== 1'b0) begin fails++; $display("[TB] FAIL single_accept: got %b want 0", tx_data_valid); end
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL single_idle: got %b want 0", busy); end
        req_valid = 4'b1111;
        #1;
        checks++; if (req_ready !== 4'b1000) begin fails++; $display("[TB] FAIL single_rr_ptr: got %b want 1000", req_ready); end
        req_valid = 4'b0000;
    endtask

    task automatic test_round_robin();
        int  order [6] = '{0, 1, 2, 3, 0, 1};
        bit  seen;
        logic [3:0] expReady;
        pulseReset();
        req_data = 32'hC3C2_C1C0; req_last = 4'hF; req_valid = 4'b1111;
        for (int p = 0; p < 6; p++) begin
            waitForPop(10, seen);
            checks++; if (!seen) begin fails++; $display("[TB] FAIL rr_timeout grant %0d: got none want pop", p); end
            expReady = 4'b0001 << order[p];
            checks++; if (req_ready !== expReady) begin fails++; $display("[TB] FAIL rr_pop %0d: got %b want %b", p, req_ready, expReady); end
            @(negedge clk);
            checks++; if (grant_id !== 2'(order[p])) begin fails++; $display("[TB] FAIL rr_grant %0d: got %0d want %0d", p, grant_id, order[p]); end
            checks++; if (tx_data !== 8'(8'hC0 + order[p])) begin fails++; $display("[TB] FAIL rr_data %0d: got %h want %h", p, tx_data, 8'(8'hC0 + order[p])); end
        end
        req_valid = 4'b0000;
        repeat (3) @(negedge clk);
    endtask

`ifdef UART_TX_ARB_PKT_LOCK_EN
    task automatic test_packet_lock();
        logic [3:0] expReady [4] = '{4'b0010, 4'b0010, 4'b0010, 4'b0001};
        logic [1:0] expGrant [4] = '{2'd1, 2'd1, 2'd1, 2'd0};
        logic [7:0] expData  [4] = '{8'h11, 8'h22, 8'h33, 8'h0A};
        bit seen;
        pulseReset();
        req_data = 32'h0000_110A; req_last = 4'b0001; req_valid = 4'b0010;
        for (int p = 0; p < 4; p++) begin
            waitForPop(10, seen);
            checks++; if (!seen) begin fails++; $display("[TB] FAIL lock_timeout pop %0d: got none want pop", p); end
            checks++; if (req_ready !== expReady[p]) begin fails++; $display("[TB] FAIL lock_pop %0d: got %b want %b", p, req_ready, expReady[p]); end
            @(negedge clk);
            checks++; if (grant_id !== expGrant[p]) begin fails++; $display("[TB] FAIL lock_grant %0d: got %0d want %0d", p, grant_id, expGrant[p]); end
            checks++; if (tx_data !== expData[p]) begin fails++; $display("[TB] FAIL lock_data %0d: got %h want %h", p, tx_data, expData[p]); end
            case (p)
                0: begin req_valid[0] = 1'b1; req_data[15:8] = 8'h22; end
                1: begin req_data[15:8] = 8'h33; req_last[1] = 1'b1; end
                2: req_valid[1] = 1'b0;
                default: req_valid[0] = 1'b0;
            endcase
        end
        req_last = 4'hF;
        repeat (3) @(negedge clk);
    endtask
`endif

    task automatic test_back_pressure();
        bit seen;
        bit ticked;
        @(negedge clk);
        baud_div = 16'd3; tx_data_ready = 1'b0; req_last = 4'hF;
        req_data = 32'h0000_005C; req_valid = 4'b0001;
        waitForPop(10, seen);
        checks++; if (req_ready !== 4'b0001) begin fails++; $display("[TB] FAIL bp_pop: got %b want 0001", req_ready); end
        @(negedge clk);
        req_valid = 4'b0011;
        for (int n = 0; n < 50; n++) begin
            #1;
            checks++; if (tx_data !== 8'h5C) begin fails++; $display("[TB] FAIL bp_data cycle %0d: got %h want 5c", n, tx_data); end
            checks++; if (tx_data_valid !== 1'b1) begin fails++; $display("[TB] FAIL bp_valid cycle %0d: got %b want 1", n, tx_data_valid); end
            checks++; if (req_ready !== 4'b0000) begin fails++; $display("[TB] FAIL bp_ready cycle %0d: got %b want 0000", n, req_ready); end
            @(negedge clk);
        end
        tx_data_ready = 1'b1; req_valid = 4'b0000;
        ticked = 1'b0;
        for (int n = 0; n < 8; n++) begin
            if (clk_enable === 1'b1) begin
                ticked = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++; if (!ticked) begin fails++; $display("[TB] FAIL bp_tick_timeout: got no tick want tick"); end
        checks++; if (tx_data_valid !== 1'b1) begin fails++; $display("[TB] FAIL bp_held_at_tick: got %b want 1", tx_data_valid); end
        @(negedge clk);
        checks++; if (tx_data_valid !== 1'b0) begin fails++; $display("[TB] FAIL bp_accept: got %b want 0", tx_data_valid); end
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL bp_idle: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_packet();
        bit seen;
        @(negedge clk);
        baud_div = 16'd0; req_data = 32'h0077_0000; req_valid = 4'b0100;
`ifdef UART_TX_ARB_PKT_LOCK_EN
        tx_data_ready = 1'b1; req_last = 4'b1011;
`else
        tx_data_ready = 1'b0;
`endif
        waitForPop(10, seen);
        checks++; if (!seen) begin fails++; $display("[TB] FAIL mid_timeout: got none want pop"); end
        @(negedge clk);
        req_valid = 4'b0000;
`ifdef UART_TX_ARB_PKT_LOCK_EN
        @(negedge clk);
        checks++; if (tx_data_valid !== 1'b0) begin fails++; $display("[TB] FAIL mid_locked_valid: got %b want 0", tx_data_valid); end
`else
        checks++; if (tx_data_valid !== 1'b1) begin fails++; $display("[TB] FAIL mid_held_valid: got %b want 1", tx_data_valid); end
`endif
        checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL mid_busy: got %b want 1", busy); end
        checks++; if (tx_data !== 8'h77) begin fails++; $display("[TB] FAIL mid_data: got %h want 77", tx_data); end
        reset_n = 1'b0;
        #1;
        checks++; if (tx_data_valid !== 1'b0) begin fails++; $display("[TB] FAIL mid_rst_valid: got %b want 0", tx_data_valid); end
        checks++; if (tx_data !== 8'h00) begin fails++; $display("[TB] FAIL mid_rst_data: got %h want 00", tx_data); end
        checks++; if (grant_id !== 2'd0) begin fails++; $display("[TB] FAIL mid_rst_grant: got %0d want 0", grant_id); end
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL mid_rst_busy: got %b want 0", busy); end
        checks++; if (clk_enable !== 1'b0) begin fails++; $display("[TB] FAIL mid_rst_tick: got %b want 0", clk_enable); end
        @(negedge clk);
        reset_n = 1'b1; tx_data_ready = 1'b1; req_last = 4'hF; req_valid = 4'b1111;
        #1;
        checks++; if (req_ready !== 4'b0001) begin fails++; $display("[TB] FAIL mid_restart_rr: got %b want 0001", req_ready); end
        req_valid = 4'b0000;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_tick();
        test_single_byte();
        test_round_robin();
`ifdef UART_TX_ARB_PKT_LOCK_EN
        test_packet_lock();
`endif
        test_back_pressure();
        test_reset_mid_packet();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
